shift_load_ctrl: RTL and testbench

- Upstream sequencer for the 4-bit right-shift register stage.
- Accepts parallel nibbles over a valid/ready handshake.
- For each nibble it issues a one-cycle `load` with the data, then exactly `SHIFT_LEN` `ena` cycles, then an optional gap.
- Supports back-pressure (`pause`) and a synchronous abort (`flush`). Reports completion to the system controller.

---
 rtl/shift_load_ctrl_pkg.sv | 23 ++
 rtl/shift_load_ctrl_if.sv | 29 ++
 rtl/shift_load_ctrl_down_cnt.sv | 44 ++++
 rtl/shift_load_ctrl.sv | 118 +++++++++++
 tb/tb_shift_load_ctrl.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_load_ctrl_pkg.sv
// Shared types and constants for the shift-register load sequencer.
package shift_pkg;

    localparam int unsigned NIB_W         = 4;
    localparam int unsigned CNT_W         = 4;
    localparam int unsigned CNT_MAX       = 15;
    localparam int unsigned SHIFT_LEN_DEF = 4;
    localparam int unsigned GAP_DEF       = 0;

    // Sequencer state encoding.
    typedef logic [1:0] state_t;
    localparam state_t StIdle  = 2'd0;
    localparam state_t StLoad  = 2'd1;
    localparam state_t StShift = 2'd2;
    localparam state_t StGap   = 2'd3;

    // Inclusive range test used for parameter legality checks.
    function automatic bit in_range(input int unsigned v, input int unsigned lo,
                                    input int unsigned hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/shift_load_ctrl_if.sv
// Upstream handshake plus shifter-side control bundle for shift_load_ctrl.
interface shift_load_ctrl_if;
    import shift_pkg::*;

    logic             in_valid;
    logic [NIB_W-1:0] in_data;
    logic             in_ready;
    logic             pause;
    logic             flush;
    logic             load;
    logic             ena;
    logic [NIB_W-1:0] data;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cnt;

    // Driven by the upstream source / system controller.
    modport master (
        output in_valid, in_data, pause, flush,
        input  in_ready, load, ena, data, busy, done, cnt
    );

    // Seen from the sequencer itself.
    modport slave (
        input  in_valid, in_data, pause, flush,
        output in_ready, load, ena, data, busy, done, cnt
    );

endinterface

// File: rtl/shift_load_ctrl_down_cnt.sv
// Loadable down counter with clear; clear beats load beats decrement, and it
// saturates at zero.
module down_cnt
    import shift_pkg::*;
#(
    parameter int unsigned Width = CNT_W
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    input  logic             clr_i,
    output logic [Width-1:0] cnt_o,
    output logic             one_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Next-count selection.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign one_o = (cnt_q == Width'(1));

endmodule

// File: rtl/shift_load_ctrl.sv
// Sequencer feeding a 4-bit right-shift stage: accept a nibble, pulse load,
// issue SHIFT_LEN enables (stretchable by pause), idle GAP cycles, report done.
module shift_load_ctrl
    import shift_pkg::*;
#(
    parameter int unsigned SHIFT_LEN = SHIFT_LEN_DEF,
    parameter int unsigned GAP       = GAP_DEF
) (
    input logic              clk,
    input logic              areset,
    shift_load_ctrl_if.slave sif
);

    if (!in_range(SHIFT_LEN, 1, CNT_MAX)) begin : g_bad_shift_len
        $error("shift_load_ctrl: SHIFT_LEN must be within 1..15");
    end
    if (!in_range(GAP, 0, CNT_MAX)) begin : g_bad_gap
        $error("shift_load_ctrl: GAP must be within 0..15");
    end

    localparam logic [CNT_W-1:0] ShiftVal = CNT_W'(SHIFT_LEN);
    localparam logic [CNT_W-1:0] GapVal   = CNT_W'(GAP);
    localparam bit               HasGap   = (GAP != 0);

    state_t           state_q, state_d;
    logic [NIB_W-1:0] data_q, data_d;
    logic             done_q, done_d;

    logic             in_ready;
    logic             hs;
    logic             shift_fire;
    logic             last_shift;
    logic             gap_load;
    logic             gap_dec;
    logic [CNT_W-1:0] shift_cnt;
    logic             shift_one;
    logic [CNT_W-1:0] gap_cnt;
    logic             gap_one;

    // Reset is folded in so nothing is accepted while areset is high.
    assign in_ready   = (state_q == StIdle) & ~sif.flush & ~areset;
    assign hs         = sif.in_valid & in_ready;
    assign shift_fire = (state_q == StShift) & ~sif.pause;
    assign last_shift = shift_fire & shift_one;
    assign gap_load   = last_shift & HasGap;
    assign gap_dec    = (state_q == StGap);

    down_cnt #(
        .Width (CNT_W)
    ) u_shift_cnt (
        .clk        (clk),
        .areset     (areset),
        .load_i     (hs),
        .load_val_i (ShiftVal),
        .dec_i      (shift_fire),
        .clr_i      (sif.flush),
        .cnt_o      (shift_cnt),
        .one_o      (shift_one)
    );

    down_cnt #(
        .Width (CNT_W)
    ) u_gap_cnt (
        .clk        (clk),
        .areset     (areset),
        .load_i     (gap_load),
        .load_val_i (GapVal),
        .dec_i      (gap_dec),
        .clr_i      (sif.flush),
        .cnt_o      (gap_cnt),
        .one_o      (gap_one)
    );

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (hs) state_d = StLoad;
            StLoad:  state_d = StShift;
            StShift: if (last_shift) state_d = HasGap ? StGap : StIdle;
            // A zero count here can only come from a corrupted counter; bail out.
            StGap:   if (gap_one || (gap_cnt == '0)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (sif.flush) begin
            state_d = StIdle;
        end
    end

    // Data capture on handshake and the completion pulse (suppressed by flush).
    always_comb begin
        data_d = hs ? sif.in_data : data_q;
        done_d = last_shift & ~sif.flush;
    end

    // State, data and done registers.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= StIdle;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    // Load has priority in the shifter, so ena stays low in the load cycle.
    assign sif.in_ready = in_ready;
    assign sif.load     = (state_q == StLoad);
    assign sif.ena      = shift_fire;
    assign sif.busy     = (state_q != StIdle);
    assign sif.data     = data_q;
    assign sif.done     = done_q;
    assign sif.cnt      = shift_cnt;

endmodule

// File: tb/tb_shift_load_ctrl.sv
// Bench for shift_load_ctrl: three instances (4/0, 4/2, 1/0), a per-cycle
// vector table on the first, hand sequences for gap, reset and SHIFT_LEN=1,
// and a scoreboard with a shifter model checking every completed nibble.
module tb_shift_load_ctrl;

    localparam int unsigned SL [3] = '{4, 4, 1};
    localparam int unsigned GP [3] = '{0, 2, 0};

    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    logic       vld [3];
    logic [3:0] din [3];
    logic       pz  [3];
    logic       fl  [3];
    logic       rdy [3];
    logic       ld  [3];
    logic       en  [3];
    logic       bz  [3];
    logic       dn  [3];
    logic [3:0] dq  [3];
    logic [3:0] cq  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        shift_load_ctrl_if ifc ();
        assign ifc.in_valid = vld[g];
        assign ifc.in_data  = din[g];
        assign ifc.pause    = pz[g];
        assign ifc.flush    = fl[g];
        assign rdy[g]       = ifc.in_ready;
        assign ld[g]        = ifc.load;
        assign en[g]        = ifc.ena;
        assign bz[g]        = ifc.busy;
        assign dn[g]        = ifc.done;
        assign dq[g]        = ifc.data;
        assign cq[g]        = ifc.cnt;

        shift_load_ctrl #(
            .SHIFT_LEN (SL[g]),
            .GAP       (GP[g])
        ) u_dut (
            .clk    (clk),
            .areset (areset),
            .sif    (ifc)
        );
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: nibbles pushed at handshake, popped at done or abandon.
    logic [3:0] sbq [3][$];
    logic       active  [3];
    int         en_cnt  [3];
    logic [3:0] model_q [3];
    logic [3:0] ld_val  [3];

    // Called once per cycle at the falling edge, with outputs stable.
    task automatic sb_step();
        logic [3:0] e;
        for (int i = 0; i < 3; i++) begin
            if (areset) begin
                sbq[i].delete();
                active[i]  = 1'b0;
                en_cnt[i]  = 0;
                model_q[i] = '0;
                continue;
            end
            if (dn[i]) begin
                chk($sformatf("sb%0d_done_has_nibble", i), int'(sbq[i].size() > 0), 1);
                if (sbq[i].size() > 0) begin
                    e = sbq[i].pop_front();
                    chk($sformatf("sb%0d_loaded_data", i), int'(ld_val[i]), int'(e));
                    chk($sformatf("sb%0d_ena_count", i), en_cnt[i], int'(SL[i]));
                    chk($sformatf("sb%0d_shifter_q", i), int'(model_q[i]),
                        int'(4'(e >> SL[i])));
                end
                active[i] = 1'b0;
            end
            if (fl[i] && active[i]) begin
                if (sbq[i].size() > 0) void'(sbq[i].pop_front());
                active[i] = 1'b0;
            end
            if (ld[i]) begin
                model_q[i] = dq[i];
                ld_val[i]  = dq[i];
                en_cnt[i]  = 0;
            end
            if (en[i]) begin
                model_q[i] = {1'b0, model_q[i][3:1]};
                en_cnt[i]++;
            end
            if (vld[i] && rdy[i]) begin
                sbq[i].push_back(din[i]);
                active[i] = 1'b1;
            end
        end
    endtask

    task automatic end_cycle();
        @(negedge clk);
        sb_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       vld;
        logic [3:0] din;
        logic       pz;
        logic       fl;
        logic       e_ld;
        logic       e_en;
        logic       e_bz;
        logic       e_dn;
        logic       e_rdy;
        logic [3:0] e_cnt;
        logic [3:0] e_data;
    } vec_t;

    vec_t vecs [$];

    task automatic add(input logic v, input logic [3:0] d, input logic p, input logic f,
                       input logic l, input logic e, input logic b, input logic dd,
                       input logic r, input logic [3:0] c, input logic [3:0] da);
        vec_t t;
        t = '{vld: v, din: d, pz: p, fl: f, e_ld: l, e_en: e, e_bz: b, e_dn: dd,
              e_rdy: r, e_cnt: c, e_data: da};
        vecs.push_back(t);
    endtask

    initial begin
        int ne;
        int nd;
        logic [9:0] rdy_pat;
        logic [9:0] ld_pat;
        logic [9:0] dn_pat;

        // vld din pz fl | ld en bz dn rdy cnt data
        // Basic nibble 1011, SHIFT_LEN=4, GAP=0.
        add(1, 4'hB, 0, 0,  0, 0, 0, 0, 1, 4'd0, 4'h0);
        add(0, 4'h0, 0, 0,  1, 0, 1, 0, 0, 4'd4, 4'hB);
        add(0, 4'h0, 0, 0,  0, 1, 1, 0, 0, 4'd4, 4'hB);
        add(0, 4'h0, 0, 0,  0, 1, 1, 0, 0, 4'd3, 4'hB);
        add(0, 4'h0, 0, 0,  0, 1, 1, 0, 0, 4'd2, 4'hB);
        add(0, 4'h0, 0, 0,  0, 1, 1, 0, 0, 4'd1, 4'hB);
        add(0, 4'h0, 0, 0,  0, 0, 0, 1, 1, 4'd0, 4'hB);
        add(0, 4'h0, 0, 0,  0, 0, 0, 0, 1, 4'd0, 4'hB);
        // Same nibble with pause in cycles 3-4.
        add(1, 4'hB, 0, 0,  0, 0, 0, 0, 1, 4'd0, 4'hB);
        add(0, 4'h0, 0, 0,  1, 0, 1, 0, 0, 4'd4, 4'hB);
        add(0, 4'h0, 0, 0,  0, 1, 1, 0, 0, 4'd4, 4'hB);
        add(0, 4'h0, 1, 0,  0, 0, 1, 0, 0, 4'd3, 4'hB);
        add(0, 4'h0, 1, 0,  0, 0, 1, 0, 0, 4'd3, 4'hB);
        add(0, 4'h0, 0, 0,  0, 1, 1, 0, 0, 4'd3, 4'hB);
        add(0, 4'h0, 0, 0,  0, 1, 1, 0, 0, 4'd2, 4'hB);
        add(0, 4'h0, 0, 0,  0, 1, 1, 0, 0, 4'd1, 4'hB);
        add(0, 4'h0, 0, 0,  0, 0, 0, 1, 1, 4'd0, 4'hB);
        // Flush in cycle 3, then flush together with in_valid while idle.
        add(1, 4'h6, 0, 0,  0, 0, 0, 0, 1, 4'd0, 4'hB);
        add(0, 4'h0, 0, 0,  1, 0, 1, 0, 0, 4'd4, 4'h6);
        add(0, 4'h0, 0, 0,  0, 1, 1, 0, 0, 4'd4, 4'h6);
        add(0, 4'h0, 0, 1,  0, 1, 1, 0, 0, 4'd3, 4'h6);
        add(0, 4'h0, 0, 0,  0, 0, 0, 0, 1, 4'd0, 4'h6);
        add(0, 4'h0, 0, 0,  0, 0, 0, 0, 1, 4'd0, 4'h6);
        add(1, 4'h9, 0, 1,  0, 0, 0, 0, 0, 4'd0, 4'h6);
        add(0, 4'h0, 0, 0,  0, 0, 0, 0, 1, 4'd0, 4'h6);

        for (int i = 0; i < 3; i++) begin
            vld[i] = 1'b0; din[i] = '0; pz[i] = 1'b0; fl[i] = 1'b0;
            active[i] = 1'b0; en_cnt[i] = 0; model_q[i] = '0; ld_val[i] = '0;
        end
        areset = 1'b1;

        // Reset state while areset is held.
        repeat (2) @(negedge clk);
        vld[0] = 1'b1;
        #1;
        chk("reset_in_ready", int'(rdy[0]), 0);
        chk("reset_load", int'(ld[0]), 0);
        chk("reset_ena", int'(en[0]), 0);
        chk("reset_busy", int'(bz[0]), 0);
        chk("reset_done", int'(dn[0]), 0);
        chk("reset_cnt", int'(cq[0]), 0);
        chk("reset_data", int'(dq[0]), 0);
        vld[0] = 1'b0;
        @(posedge clk);
        #1;
        areset = 1'b0;

        // Table-driven cycles on instance 0.
        for (int r = 0; r < vecs.size(); r++) begin
            vld[0] = vecs[r].vld;
            din[0] = vecs[r].din;
            pz[0]  = vecs[r].pz;
            fl[0]  = vecs[r].fl;
            @(negedge clk);
            chk($sformatf("row%0d_load", r), int'(ld[0]), int'(vecs[r].e_ld));
            chk($sformatf("row%0d_ena", r), int'(en[0]), int'(vecs[r].e_en));
            chk($sformatf("row%0d_busy", r), int'(bz[0]), int'(vecs[r].e_bz));
            chk($sformatf("row%0d_done", r), int'(dn[0]), int'(vecs[r].e_dn));
            chk($sformatf("row%0d_in_ready", r), int'(rdy[0]), int'(vecs[r].e_rdy));
            chk($sformatf("row%0d_cnt", r), int'(cq[0]), int'(vecs[r].e_cnt));
            chk($sformatf("row%0d_data", r), int'(dq[0]), int'(vecs[r].e_data));
            sb_step();
            @(posedge clk);
            #1;
        end
        vld[0] = 1'b0; fl[0] = 1'b0; pz[0] = 1'b0;

        // GAP=2, back-to-back A then 5 with in_valid held.
        rdy_pat = 10'b01_0000_0001;
        ld_pat  = 10'b10_0000_0010;
        dn_pat  = 10'b00_0100_0000;
        vld[1] = 1'b1;
        din[1] = 4'hA;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("gap_c%0d_in_ready", c), int'(rdy[1]), int'(rdy_pat[c]));
            chk($sformatf("gap_c%0d_load", c), int'(ld[1]), int'(ld_pat[c]));
            chk($sformatf("gap_c%0d_done", c), int'(dn[1]), int'(dn_pat[c]));
            if (c == 9) chk("gap_second_data", int'(dq[1]), 5);
            sb_step();
            @(posedge clk);
            #1;
            if (c == 0) din[1] = 4'h5;
            if (c == 8) vld[1] = 1'b0;
        end
        repeat (10) end_cycle();

        // Asynchronous reset in the middle of a shift phase.
        vld[0] = 1'b1;
        din[0] = 4'h3;
        end_cycle();
        vld[0] = 1'b0;
        repeat (2) end_cycle();
        #2;
        chk("arst_pre_ena", int'(en[0]), 1);
        areset = 1'b1;
        #1;
        chk("arst_load", int'(ld[0]), 0);
        chk("arst_ena", int'(en[0]), 0);
        chk("arst_busy", int'(bz[0]), 0);
        chk("arst_done", int'(dn[0]), 0);
        chk("arst_in_ready", int'(rdy[0]), 0);
        chk("arst_cnt", int'(cq[0]), 0);
        end_cycle();
        areset = 1'b0;
        vld[0] = 1'b1;
        din[0] = 4'hC;
        ne = 0;
        nd = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (en[0]) ne++;
            if (dn[0]) nd++;
            sb_step();
            @(posedge clk);
            #1;
            vld[0] = 1'b0;
        end
        chk("arst_after_ena_pulses", ne, 4);
        chk("arst_after_done_pulses", nd, 1);

        // SHIFT_LEN=1, continuous in_valid: one load every three cycles.
        vld[2] = 1'b1;
        din[2] = 4'h0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("sl1_c%0d_load", c), int'(ld[2]), int'(c % 3 == 1));
            chk($sformatf("sl1_c%0d_ena", c), int'(en[2]), int'(c % 3 == 2));
            chk($sformatf("sl1_c%0d_done", c), int'(dn[2]), int'((c % 3 == 0) && (c > 0)));
            sb_step();
            @(posedge clk);
            #1;
            din[2] = 4'(c + 1);
        end
        vld[2] = 1'b0;
        repeat (4) end_cycle();

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("sb%0d_drained", i), sbq[i].size(), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
